// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS core: load-use bubble
// insertion, downstream hold, and a saturating bubble counter.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          valid_ID,
  input  logic          write_ID,
  input  logic          DM_w_ID,
  input  logic [3:0]    aluc_ID,
  input  logic          mux_alua_ID,
  input  logic [1:0]    mux_alub_ID,
  input  logic [1:0]    mux_wdata_ID,
  input  logic [AW-1:0] waddr_ID,
  input  logic [AW-1:0] rs_addr_ID,
  input  logic [AW-1:0] rt_addr_ID,
  input  logic          uses_rs_ID,
  input  logic          uses_rt_ID,
  input  logic [DW-1:0] rs_data_ID,
  input  logic [DW-1:0] rt_data_ID,
  input  logic [DW-1:0] imm_ID,
  input  logic [4:0]    shamt_ID,
  input  logic [DW-1:0] pc_ID,
  output logic          valid_EX,
  output logic          write_EX,
  output logic          DM_w_EX,
  output logic [3:0]    aluc_EX,
  output logic          mux_alua_EX,
  output logic [1:0]    mux_alub_EX,
  output logic [1:0]    mux_wdata_EX,
  output logic [AW-1:0] waddr_EX,
  output logic [DW-1:0] rs_data_EX,
  output logic [DW-1:0] rt_data_EX,
  output logic [DW-1:0] imm_EX,
  output logic [4:0]    shamt_EX,
  output logic [DW-1:0] pc_EX,
  output logic          stall_ID,
  output logic [31:0]   bubble_cnt
);

  logic load_use;
  logic clear_slot;

  // A load sitting in EX whose result is needed by the instruction in ID.
  always_comb begin
    load_use = valid_EX & write_EX & (mux_wdata_EX == 2'b01) &
               (waddr_EX != '0) & valid_ID &
               ((uses_rs_ID & (rs_addr_ID == waddr_EX)) |
                (uses_rt_ID & (rt_addr_ID == waddr_EX)));
  end

  assign stall_ID   = ~rst & (hold | load_use);
  // Bubbles and invalid slots both enter EX as an all-zero word.
  assign clear_slot = load_use | ~valid_ID;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_EX     <= 1'b0;
      write_EX     <= 1'b0;
      DM_w_EX      <= 1'b0;
      aluc_EX      <= '0;
      mux_alua_EX  <= 1'b0;
      mux_alub_EX  <= '0;
      mux_wdata_EX <= '0;
      waddr_EX     <= '0;
      rs_data_EX   <= '0;
      rt_data_EX   <= '0;
      imm_EX       <= '0;
      shamt_EX     <= '0;
      pc_EX        <= '0;
      bubble_cnt   <= '0;
    end else if (!hold) begin
      valid_EX     <= clear_slot ? 1'b0 : valid_ID;
      write_EX     <= clear_slot ? 1'b0 : write_ID;
      DM_w_EX      <= clear_slot ? 1'b0 : DM_w_ID;
      aluc_EX      <= clear_slot ? '0 : aluc_ID;
      mux_alua_EX  <= clear_slot ? 1'b0 : mux_alua_ID;
      mux_alub_EX  <= clear_slot ? '0 : mux_alub_ID;
      mux_wdata_EX <= clear_slot ? '0 : mux_wdata_ID;
      waddr_EX     <= clear_slot ? '0 : waddr_ID;
      rs_data_EX   <= clear_slot ? '0 : rs_data_ID;
      rt_data_EX   <= clear_slot ? '0 : rt_data_ID;
      imm_EX       <= clear_slot ? '0 : imm_ID;
      shamt_EX     <= clear_slot ? '0 : shamt_ID;
      pc_EX        <= clear_slot ? '0 : pc_ID;
      if (load_use && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, randomized run against a
// struct-level reference model, and counter saturation via force.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid, write, dmw;
    logic [3:0]  aluc;
    logic        alua;
    logic [1:0]  alub, wdata;
    logic [4:0]  waddr;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  shamt;
    logic [31:0] pc;
  } ex_t;

  typedef struct {
    string      name;
    bit         rst, hold;
    ex_t        f;
    bit         urs;
    bit [4:0]   rs;
    bit         urt;
    bit [4:0]   rt;
    bit         stall;
    ex_t        exp;
    bit [31:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, hold, valid_ID, write_ID, DM_w_ID, mux_alua_ID;
  logic [3:0]  aluc_ID;
  logic [1:0]  mux_alub_ID, mux_wdata_ID;
  logic [4:0]  waddr_ID, rs_addr_ID, rt_addr_ID, shamt_ID;
  logic        uses_rs_ID, uses_rt_ID;
  logic [31:0] rs_data_ID, rt_data_ID, imm_ID, pc_ID;
  logic        valid_EX, write_EX, DM_w_EX, mux_alua_EX, stall_ID;
  logic [3:0]  aluc_EX;
  logic [1:0]  mux_alub_EX, mux_wdata_EX;
  logic [4:0]  waddr_EX, shamt_EX;
  logic [31:0] rs_data_EX, rt_data_EX, imm_EX, pc_EX, bubble_cnt;
  ex_t         got_ex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .valid_ID(valid_ID), .write_ID(write_ID),
    .DM_w_ID(DM_w_ID), .aluc_ID(aluc_ID), .mux_alua_ID(mux_alua_ID),
    .mux_alub_ID(mux_alub_ID), .mux_wdata_ID(mux_wdata_ID), .waddr_ID(waddr_ID),
    .rs_addr_ID(rs_addr_ID), .rt_addr_ID(rt_addr_ID), .uses_rs_ID(uses_rs_ID),
    .uses_rt_ID(uses_rt_ID), .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID),
    .imm_ID(imm_ID), .shamt_ID(shamt_ID), .pc_ID(pc_ID),
    .valid_EX(valid_EX), .write_EX(write_EX), .DM_w_EX(DM_w_EX), .aluc_EX(aluc_EX),
    .mux_alua_EX(mux_alua_EX), .mux_alub_EX(mux_alub_EX), .mux_wdata_EX(mux_wdata_EX),
    .waddr_EX(waddr_EX), .rs_data_EX(rs_data_EX), .rt_data_EX(rt_data_EX),
    .imm_EX(imm_EX), .shamt_EX(shamt_EX), .pc_EX(pc_EX),
    .stall_ID(stall_ID), .bubble_cnt(bubble_cnt)
  );

  assign got_ex = {valid_EX, write_EX, DM_w_EX, aluc_EX, mux_alua_EX, mux_alub_EX,
                   mux_wdata_EX, waddr_EX, rs_data_EX, rt_data_EX, imm_EX, shamt_EX, pc_EX};

  function automatic ex_t mkf(bit va, bit wr, bit dm, bit [3:0] al, bit [1:0] wd,
                              bit [4:0] wa, bit [31:0] rd, bit [31:0] td);
    ex_t f = '0;
    f.valid = va; f.write = wr; f.dmw = dm; f.aluc = al;
    f.wdata = wd; f.waddr = wa; f.rsd = rd; f.rtd = td;
    return f;
  endfunction

  function automatic vec_t mkv(string n, bit r, bit h, ex_t f, bit urs, bit [4:0] rs,
                               bit urt, bit [4:0] rt, bit st, ex_t e, bit [31:0] c);
    vec_t v;
    v.name = n; v.rst = r; v.hold = h; v.f = f; v.urs = urs; v.rs = rs;
    v.urt = urt; v.rt = rt; v.stall = st; v.exp = e; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [149:0] got, input logic [149:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit h, input ex_t f, input bit urs,
                       input bit [4:0] rs, input bit urt, input bit [4:0] rt);
    rst = r; hold = h;
    valid_ID = f.valid; write_ID = f.write; DM_w_ID = f.dmw; aluc_ID = f.aluc;
    mux_alua_ID = f.alua; mux_alub_ID = f.alub; mux_wdata_ID = f.wdata;
    waddr_ID = f.waddr; rs_data_ID = f.rsd; rt_data_ID = f.rtd; imm_ID = f.imm;
    shamt_ID = f.shamt; pc_ID = f.pc;
    uses_rs_ID = urs; rs_addr_ID = rs; uses_rt_ID = urt; rt_addr_ID = rt;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.rst, v.hold, v.f, v.urs, v.rs, v.urt, v.rt);
    #1;
    chk({v.name, ".stall"}, 150'(stall_ID), 150'(v.stall));
    @(posedge clk);
    #1;
    chk({v.name, ".ex"}, got_ex, v.exp);
    chk({v.name, ".cnt"}, 150'(bubble_cnt), 150'(v.cnt));
  endtask

  vec_t vt[$];
  vec_t sat[$];
  ex_t  add_w, lw8, dep, dep2, lw0, rs0, nouse, alu8, rsalu8, lwc, hdep, inv, lwd, dep3;
  ex_t  junk, m, f, nm;
  bit [31:0] mc;
  bit   r, h, urs, urt, hz, est;
  bit [4:0] rs, rt;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 5'd0, 1'b0, 5'd0);
    junk   = mkf(1, 1, 1, 4'hF, 2'b01, 5'd8, 32'hDEAD, 32'hBEEF);
    add_w  = mkf(1, 1, 0, 4'h2, 2'b00, 5'd3, 32'd5, 32'd7);
    lw8    = mkf(1, 1, 0, 4'h0, 2'b01, 5'd8, 32'h20, 0);
    dep    = mkf(1, 1, 0, 4'h2, 2'b00, 5'd9, 32'h11, 0);
    lw0    = mkf(1, 1, 0, 4'h0, 2'b01, 5'd0, 32'h30, 0);
    rs0    = mkf(1, 1, 0, 4'h2, 2'b00, 5'd4, 32'h31, 0);
    nouse  = mkf(1, 1, 0, 4'h2, 2'b00, 5'd5, 32'h41, 0);
    alu8   = mkf(1, 1, 0, 4'h2, 2'b00, 5'd8, 32'h50, 0);
    rsalu8 = mkf(1, 1, 0, 4'h2, 2'b00, 5'd6, 32'h51, 0);
    lwc    = mkf(1, 1, 0, 4'h0, 2'b01, 5'd8, 32'h60, 0);
    hdep   = mkf(1, 1, 0, 4'h2, 2'b00, 5'd7, 32'h61, 0);
    inv    = mkf(0, 1, 1, 4'h2, 2'b01, 5'd7, 32'h70, 32'h71);
    lwd    = mkf(1, 1, 0, 4'h0, 2'b01, 5'd8, 32'h80, 0);
    dep3   = mkf(1, 1, 0, 4'h2, 2'b00, 5'd7, 32'h81, 0);
    dep2   = mkf(1, 1, 0, 4'h2, 2'b00, 5'd9, 32'h91, 0);

    vt.push_back(mkv("rst0",    1, 0, junk,   1, 8, 1, 8, 0, '0, 0));
    vt.push_back(mkv("rst1",    1, 0, junk,   1, 8, 1, 8, 0, '0, 0));
    vt.push_back(mkv("add",     0, 0, add_w,  1, 1, 1, 2, 0, add_w, 0));
    vt.push_back(mkv("lw8",     0, 0, lw8,    1, 3, 0, 0, 0, lw8, 0));
    vt.push_back(mkv("lu_bub",  0, 0, dep,    1, 8, 0, 0, 1, '0, 1));
    vt.push_back(mkv("lu_load", 0, 0, dep,    1, 8, 0, 0, 0, dep, 1));
    vt.push_back(mkv("lw0",     0, 0, lw0,    1, 9, 0, 0, 0, lw0, 1));
    vt.push_back(mkv("rs_r0",   0, 0, rs0,    1, 0, 1, 0, 0, rs0, 1));
    vt.push_back(mkv("lw8b",    0, 0, lw8,    0, 0, 0, 0, 0, lw8, 1));
    vt.push_back(mkv("nouse",   0, 0, nouse,  0, 8, 0, 8, 0, nouse, 1));
    vt.push_back(mkv("alu8",    0, 0, alu8,   0, 0, 0, 0, 0, alu8, 1));
    vt.push_back(mkv("rsalu8",  0, 0, rsalu8, 1, 8, 0, 0, 0, rsalu8, 1));
    vt.push_back(mkv("lw8c",    0, 0, lwc,    0, 0, 0, 0, 0, lwc, 1));
    vt.push_back(mkv("hold1",   0, 1, hdep,   0, 0, 1, 8, 1, lwc, 1));
    vt.push_back(mkv("hold2",   0, 1, hdep,   0, 0, 1, 8, 1, lwc, 1));
    vt.push_back(mkv("hold3",   0, 1, hdep,   0, 0, 1, 8, 1, lwc, 1));
    vt.push_back(mkv("hold_bub",0, 0, hdep,   0, 0, 1, 8, 1, '0, 2));
    vt.push_back(mkv("hold_ld", 0, 0, hdep,   0, 0, 1, 8, 0, hdep, 2));
    vt.push_back(mkv("invalid", 0, 0, inv,    1, 7, 1, 7, 0, '0, 2));
    vt.push_back(mkv("lw8d",    0, 0, lwd,    0, 0, 0, 0, 0, lwd, 2));
    vt.push_back(mkv("rst_mid", 1, 0, dep3,   1, 8, 0, 0, 0, '0, 0));
    vt.push_back(mkv("post_rst",0, 0, dep3,   1, 8, 0, 0, 0, dep3, 0));
    foreach (vt[i]) run_vec(vt[i]);

    // Randomized run against the reference model; first cycle resets it.
    m = '0; mc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      r = (i == 0) || ($urandom_range(0, 63) == 0);
      h = ($urandom_range(0, 7) == 0);
      f = '0;
      f.valid = ($urandom_range(0, 5) != 0);
      f.write = 1'($urandom); f.dmw = 1'($urandom); f.aluc = 4'($urandom);
      f.alua = 1'($urandom); f.alub = 2'($urandom); f.wdata = 2'($urandom);
      f.waddr = 5'($urandom_range(0, 3)); f.rsd = $urandom; f.rtd = $urandom;
      f.imm = $urandom; f.shamt = 5'($urandom); f.pc = $urandom;
      urs = 1'($urandom); urt = 1'($urandom);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      drive(r, h, f, urs, rs, urt, rt);
      hz  = m.valid && m.write && (m.wdata == 2'b01) && (m.waddr != 0) && f.valid &&
            ((urs && rs == m.waddr) || (urt && rt == m.waddr));
      est = !r && (h || hz);
      if (r) begin
        nm = '0; mc = 0;
      end else if (h) begin
        nm = m;
      end else if (hz) begin
        nm = '0;
        if (mc != 32'hFFFF_FFFF) mc = mc + 1;
      end else begin
        nm = f.valid ? f : '0;
      end
      #1;
      chk("rand.stall", 150'(stall_ID), 150'(est));
      @(posedge clk);
      #1;
      m = nm;
      chk("rand.ex", got_ex, m);
      chk("rand.cnt", 150'(bubble_cnt), 150'(mc));
    end

    // Saturation: preload the counter one below the top, then two bubbles.
    run_vec(mkv("sat_rst", 1, 0, junk, 0, 0, 0, 0, 0, '0, 0));
    @(negedge clk);
    drive(1'b0, 1'b1, '0, 1'b0, 5'd0, 1'b0, 5'd0);
    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt;
    sat.push_back(mkv("sat_lw",   0, 0, lw8,  0, 0, 0, 0, 0, lw8,  32'hFFFF_FFFE));
    sat.push_back(mkv("sat_bub1", 0, 0, dep2, 1, 8, 0, 0, 1, '0,   32'hFFFF_FFFF));
    sat.push_back(mkv("sat_ld",   0, 0, dep2, 1, 8, 0, 0, 0, dep2, 32'hFFFF_FFFF));
    sat.push_back(mkv("sat_lw2",  0, 0, lw8,  0, 0, 0, 0, 0, lw8,  32'hFFFF_FFFF));
    sat.push_back(mkv("sat_bub2", 0, 0, dep2, 1, 8, 0, 0, 1, '0,   32'hFFFF_FFFF));
    foreach (sat[i]) run_vec(sat[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the five-stage MIPS core. It latches the decoded control word and operands from the ID-stage decoder into EX-side registers every cycle. It detects load-use hazards against the instruction currently in EX and inserts a bubble when one is found. It also honours a downstream hold and keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- DW, 32, datapath width (operands, immediate, PC)
- AW, 5, register-address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  downstream freeze; EX register keeps its contents
- valid_ID  in  1  ID slot holds a real instruction
- write_ID  in  1  register-file write enable
- DM_w_ID  in  1  data-memory write enable
- aluc_ID  in  4  ALU opcode
- mux_alua_ID  in  1  ALU A select (1 = shamt)
- mux_alub_ID  in  2  ALU B select
- mux_wdata_ID  in  2  writeback source (00 ALU, 01 DM, 10 link)
- waddr_ID  in  AW  resolved destination register
- rs_addr_ID, rt_addr_ID  in  AW each  source register numbers
- uses_rs_ID, uses_rt_ID  in  1 each  instruction reads rs / rt (SW counts as reading rt)
- rs_data_ID, rt_data_ID  in  DW each  operand values
- imm_ID  in  DW  extended immediate
- shamt_ID  in  5  shift amount
- pc_ID  in  DW  link value (PC+8)
- valid_EX, write_EX, DM_w_EX, aluc_EX, mux_alua_EX, mux_alub_EX, mux_wdata_EX, waddr_EX, rs_data_EX, rt_data_EX, imm_EX, shamt_EX, pc_EX  out  (widths as ID counterparts)  registered EX copies
- stall_ID  out  1  combinational; IF and IF/ID must hold this cycle
- bubble_cnt  out  32  number of load-use bubbles inserted, saturating

## Operation
- load_use = valid_EX & write_EX & (mux_wdata_EX == 01) & (waddr_EX != 0) & valid_ID & ((uses_rs_ID & rs_addr_ID == waddr_EX) | (uses_rt_ID & rt_addr_ID == waddr_EX)).
- stall_ID = hold | load_use. It is combinational from the EX registers and ID inputs. It is forced to 0 while rst = 1.
- Per-edge priority: rst > hold > load_use > load.
  - rst: all EX outputs 0 and bubble_cnt 0.
  - hold: every EX register and bubble_cnt retain their values.
  - load_use (no hold): bubble. All EX fields are written 0, so valid_EX, write_EX and DM_w_EX are all 0. bubble_cnt is incremented, saturating at 0xFFFFFFFF.
  - otherwise: every EX field is loaded from its ID counterpart, including valid_ID.
- If valid_ID = 0 on a load cycle, the whole EX slot is written as zeros, so write_EX and DM_w_EX are never asserted for an invalid slot.
- A bubble in EX has mux_wdata_EX = 00, so it cannot trigger load_use on the next cycle. A load-use case therefore stalls exactly one cycle.
- Writes to register $0 never cause a stall.
- The block does no arithmetic beyond the destination-address comparison and the counter.

## Timing
- One-cycle latency from ID inputs to EX outputs on a load edge.
- Reset value of every registered output is 0. This includes valid_EX, all control fields, data fields and bubble_cnt.
- Reset mid-stall: the EX slot clears on that edge. stall_ID is 0 the following cycle unless hold is asserted.
- Simultaneous hold and load_use:
  - hold wins; no bubble is inserted and the counter does not move.
  - The hazard re-evaluates after hold drops, and the bubble is inserted then.
- The counter saturates: at 0xFFFFFFFF a further bubble leaves it unchanged.

## Test plan
- Reset: assert rst for 2 cycles with random ID inputs. Required: all EX outputs 0, bubble_cnt 0, stall_ID 0.
- Plain pass-through: ADD-style word (write_ID=1, aluc_ID=0010, waddr_ID=3, rs_data_ID=5, rt_data_ID=7). Required: next cycle write_EX=1, aluc_EX=0010, waddr_EX=3, rs_data_EX=5, rt_data_EX=7, valid_EX=1.
- Load-use: LW into $8 in EX, then ID has uses_rs_ID=1, rs_addr_ID=8. Required:
  - stall_ID=1 for exactly one cycle.
  - The next EX slot is all zeros and bubble_cnt becomes 1.
  - The cycle after, the dependent instruction loads into EX.
- No false stall:
  - LW to $0 with rs_addr_ID=0: stall_ID=0.
  - LW to $8 with uses_rs_ID=0 and rs_addr_ID=8: stall_ID=0.
  - ALU write (mux_wdata_EX=00) to $8 with rs_addr_ID=8: stall_ID=0.
- Hold over hazard: the load-use condition is present and hold=1 for 3 cycles. Required:
  - EX registers are unchanged, stall_ID=1 and bubble_cnt is unchanged during the hold.
  - After hold drops, one bubble is inserted and bubble_cnt increments by 1.
- Saturation: preload bubble_cnt to 0xFFFFFFFE via repeated hazards or force. Two further bubbles leave it at 0xFFFFFFFF.
